// File: rtl/imem_loader_pkg.sv
// ============================================================================
// imem_loader_pkg : shared FSM states and error codes for the IMEM boot loader
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

`default_nettype wire

// File: rtl/loader_word_asm.sv
// ============================================================================
// loader_word_asm : 2-bit byte lane counter with little-endian word assembly
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module loader_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [1:0]  r_cnt;
  logic [31:0] r_word;

  // o_word already contains the byte being accepted, so the 4th byte completes it combinationally
  always_comb begin
    o_word = r_word;
    case (r_cnt)
      2'd0:    o_word[7:0]   = i_byte;
      2'd1:    o_word[15:8]  = i_byte;
      2'd2:    o_word[23:16] = i_byte;
      default: o_word[31:24] = i_byte;
    endcase
  end

  assign o_word_valid = i_byte_valid && (r_cnt == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_clear) begin
      r_cnt  <= 2'd0;
      r_word <= 32'd0;
    end else if (i_byte_valid) begin
      r_cnt  <= r_cnt + 2'd1;
      r_word <= o_word;
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : boot-time byte-stream to IMEM writer with length and checksum
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_rx_ready,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_din,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_error,
  output logic [1:0]        o_err_code,
  output logic [ADDR_W:0]   o_words_loaded
);

  localparam int              TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   c_TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit              c_TO_EN   = (TIMEOUT > 0);
  localparam logic [ADDR_W:0] c_ONE     = (ADDR_W+1)'(1);

  state_t            r_state, w_next;
  logic [1:0]        r_err_code, w_err_next;
  logic [ADDR_W:0]   r_len, r_words, w_words_inc;
  logic [31:0]       r_sum, r_din, w_word;
  logic [TW-1:0]     r_timer;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we, w_accept, w_wv, w_timeout, w_clear, w_last_word;

  assign o_rx_ready  = (r_state == LEN) || (r_state == DATA) || (r_state == CSUM);
  assign w_accept    = i_rx_valid && o_rx_ready;
  assign w_words_inc = r_words + c_ONE;
  assign w_last_word = (w_words_inc == r_len);
  assign w_timeout   = c_TO_EN && o_rx_ready && !w_accept && (r_timer == c_TO_LAST);
  assign w_clear     = (w_next != r_state);

  loader_word_asm u_word_asm (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_clear),
    .i_byte_valid (w_accept),
    .i_byte       (i_rx_data),
    .o_word       (w_word),
    .o_word_valid (w_wv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // A completed word always outranks a timeout landing on the same cycle
  always_comb begin
    w_next     = r_state;
    w_err_next = r_err_code;
    unique case (r_state)
      IDLE: if (i_start) w_next = LEN;
      LEN: begin
        if (w_wv) begin
          if (w_word > 32'(DEPTH)) begin
            w_next     = ERR;
            w_err_next = ERR_LEN;
          end else if (w_word == 32'd0) begin
            w_next = CSUM;
          end else begin
            w_next = DATA;
          end
        end else if (w_timeout) begin
          w_next     = ERR;
          w_err_next = ERR_TIMEOUT;
        end
      end
      DATA: begin
        if (w_wv) begin
          if (w_last_word) w_next = CSUM;
        end else if (w_timeout) begin
          w_next     = ERR;
          w_err_next = ERR_TIMEOUT;
        end
      end
      CSUM: begin
        if (w_wv) begin
          if (w_word == r_sum) begin
            w_next = DONE;
          end else begin
            w_next     = ERR;
            w_err_next = ERR_CSUM;
          end
        end else if (w_timeout) begin
          w_next     = ERR;
          w_err_next = ERR_TIMEOUT;
        end
      end
      DONE: if (i_start) w_next = LEN;
      ERR: begin
        if (i_start) begin
          w_next     = LEN;
          w_err_next = ERR_NONE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_code <= ERR_NONE;
      r_len      <= '0;
      r_words    <= '0;
      r_sum      <= 32'd0;
      r_timer    <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_din      <= 32'd0;
    end else begin
      r_we       <= 1'b0;
      r_err_code <= w_err_next;

      if (w_accept || !o_rx_ready || w_clear || !c_TO_EN) r_timer <= '0;
      else                                                 r_timer <= r_timer + TW'(1);

      if ((r_state == LEN) && w_wv) r_len <= w_word[ADDR_W:0];

      if ((r_state == DATA) && w_wv) begin
        r_we    <= 1'b1;
        r_din   <= w_word;
        r_addr  <= r_words[ADDR_W-1:0];
        r_words <= w_words_inc;
        r_sum   <= r_sum + w_word;
      end

      // Every new load restarts at word 0 with an empty sum
      if ((w_next == LEN) && (r_state != LEN)) begin
        r_words <= '0;
        r_sum   <= 32'd0;
      end
    end
  end

  assign o_imem_we      = r_we;
  assign o_imem_addr    = r_addr;
  assign o_imem_din     = r_din;
  assign o_cpu_hold     = (r_state != DONE);
  assign o_done         = (r_state == DONE);
  assign o_error        = (r_state == ERR);
  assign o_err_code     = r_err_code;
  assign o_words_loaded = r_words;

endmodule

`default_nettype wire
